axis_rule_filter: RTL
=====================

// Module: axis_rule_filter
// PURPOSE
//  Parametrised AXI4-Stream packet filter: second generation of the 32-bit single-rule filter.
//  Header = first beat of each packet. Compared against NUM_RULES masked match rules.
//  Whole packet forwarded or dropped. Allow-list or deny-list mode. Pass/drop statistics.
//  Sits between an upstream AXI4-Stream source and the downstream sink; one registered output stage.
// PARAMETERS
//  DATA_WIDTH   32  tdata width in bits; multiple of 8, >= FIELD_LSB+FIELD_WIDTH
//  FIELD_LSB     0  LSB of the match field within the header beat tdata
//  FIELD_WIDTH  16  match field width in bits
//  NUM_RULES     4  number of match rules, 1..16
//  COUNT_WIDTH  32  width of statistics counters
// PORTS
//  aclk            in   1                      clock; all logic rising-edge
//  aresetn         in   1                      asynchronous active-low reset
//  in_tvalid       in   1                      upstream beat valid
//  in_tready       out  1                      upstream beat accepted
//  in_tdata        in   DATA_WIDTH             upstream data
//  in_tkeep        in   DATA_WIDTH/8           upstream byte enables, passed through unchanged
//  in_tlast        in   1                      last beat of packet
//  out_tvalid      out  1                      downstream beat valid
//  out_tready      in   1                      downstream ready
//  out_tdata       out  DATA_WIDTH             forwarded data
//  out_tkeep       out  DATA_WIDTH/8           forwarded byte enables
//  out_tlast       out  1                      forwarded last
//  cfg_mode        in   1                      0=allow-list (forward on match), 1=deny-list (drop on match)
//  cfg_rule_en     in   NUM_RULES              per-rule enable
//  cfg_rule_value  in   NUM_RULES*FIELD_WIDTH  rule i value at [i*FIELD_WIDTH +: FIELD_WIDTH]
//  cfg_rule_mask   in   NUM_RULES*FIELD_WIDTH  rule i mask; 1 = bit compared
//  pass_count      out  COUNT_WIDTH            packets forwarded (counted at header)
//  drop_count      out  COUNT_WIDTH            packets dropped (counted at header)
// BEHAVIOUR
//  Reset: state=HDR; out_tvalid=0; out_tdata/out_tkeep/out_tlast=0; pass_count=drop_count=0.
//  Reset is legal mid-packet. Partial packet is discarded. First beat after reset is a header.
//  Match: rule i hits when cfg_rule_en[i] && ((field ^ value_i) & mask_i)==0.
//    match = OR of all rule hits. Mask all-zero on an enabled rule matches everything.
//  Decision: fwd = cfg_mode ? !match : match. No rules enabled => match=0.
//    Allow-list with no rules enabled drops all packets; deny-list with no rules enabled forwards all.
//  Config is sampled only on the accepted header beat. Changes mid-packet do not affect the packet in flight.
//  FSM (advances only on an accepted beat, in_tvalid && in_tready):
//    HDR : evaluate fwd. fwd=1 -> beat to output, pass_count++; else drop_count++.
//          tlast=1 -> stay HDR. Otherwise -> PASS if fwd, else -> DROP.
//    PASS: beat to output; tlast -> HDR.
//    DROP: beat discarded; tlast -> HDR.
//  Output stage: single register.
//    in_tready = (state==DROP) || (state==HDR && !fwd) || !out_tvalid || out_tready.
//    Dropped beats are consumed at 1 beat/cycle regardless of out_tready.
//    Forwarded beats: latency 1 cycle (accept at edge N, out_tvalid high after edge N).
//    Full throughput when out_tready=1.
//    out_tvalid deasserts only when out_tready=1 and no new forwarded beat is loaded.
//    Output data is held stable while out_tvalid && !out_tready (AXI rule).
//  Counters wrap modulo 2^COUNT_WIDTH. Each increments at most once per cycle.
//  No combinational path from in_* to out_*.
// TESTING
//  Configuration used in all tests unless stated: DATA_WIDTH=32, FIELD_LSB=0, FIELD_WIDTH=16, NUM_RULES=4.
//  1 Allow-list: mode=0, rule0 en, value=16'h1234, mask=16'hFFFF.
//    3-beat pkt hdr=32'hAAAA1234 -> all 3 beats out, tlast on 3rd, pass_count=1.
//    Then hdr=32'h00001235 -> 0 beats out, drop_count=1.
//  2 Deny-list masked: mode=1, rule2 en, value=16'h0A00, mask=16'hFF00.
//    hdr field 16'h0A7F -> pkt dropped, in_tready=1 every cycle even with out_tready=0.
//    Then field 16'h0B00 -> forwarded.
//  3 Backpressure: forwarded 8-beat pkt, out_tready toggles 1,0,0,1,...
//    -> all 8 beats in order, data stable while stalled, no beat lost or duplicated.
//  4 Single-beat pkts back-to-back: alternating pass/drop headers, each with tlast=1, out_tready=1
//    -> pass_count and drop_count each 50 after 100 pkts; FSM never leaves HDR.
//  5 Mid-packet config change: rule disabled after header of a forwarded 4-beat pkt
//    -> remaining beats still forwarded; next pkt dropped.
//  6 Reset mid-packet: aresetn low during beat 2 of a 5-beat pkt
//    -> outputs 0 immediately (asynchronous); next accepted beat treated as header; counters 0.

Source files
------------

// File: rtl/axis_rule_filter.sv
// -----------------------------------------------------------------------------
// axis_rule_filter
//   AXI4-Stream packet filter. The first beat of each packet (the header) has a
//   field of FIELD_WIDTH bits at FIELD_LSB compared against NUM_RULES masked
//   match rules. The whole packet is then forwarded or dropped, in allow-list
//   (forward on match) or deny-list (drop on match) mode. Forwarded and dropped
//   packets are counted at their header. Forwarded beats leave through a single
//   output register, so there is no combinational path from in_* to out_*.
//
// Ports
//   aclk, aresetn            clock (rising edge), asynchronous active-low reset
//   in_tvalid/tready/tdata/tkeep/tlast     upstream AXI4-Stream slave
//   out_tvalid/tready/tdata/tkeep/tlast    downstream AXI4-Stream master
//   cfg_mode                 0 = allow-list, 1 = deny-list
//   cfg_rule_en              per-rule enable
//   cfg_rule_value           rule i value at [i*FIELD_WIDTH +: FIELD_WIDTH]
//   cfg_rule_mask            rule i mask, 1 = bit compared
//   pass_count, drop_count   packet statistics, wrap modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module axis_rule_filter #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIELD_LSB   = 0,
  parameter int FIELD_WIDTH = 16,
  parameter int NUM_RULES   = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             in_tvalid,
  output logic                             in_tready,
  input  logic [DATA_WIDTH-1:0]            in_tdata,
  input  logic [DATA_WIDTH/8-1:0]          in_tkeep,
  input  logic                             in_tlast,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic [DATA_WIDTH-1:0]            out_tdata,
  output logic [DATA_WIDTH/8-1:0]          out_tkeep,
  output logic                             out_tlast,
  input  logic                             cfg_mode,
  input  logic [NUM_RULES-1:0]             cfg_rule_en,
  input  logic [NUM_RULES*FIELD_WIDTH-1:0] cfg_rule_value,
  input  logic [NUM_RULES*FIELD_WIDTH-1:0] cfg_rule_mask,
  output logic [COUNT_WIDTH-1:0]           pass_count,
  output logic [COUNT_WIDTH-1:0]           drop_count
);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // OR of all enabled rule hits; an enabled rule with a zero mask hits anything.
  function automatic logic rule_match(
    input logic [FIELD_WIDTH-1:0]           field,
    input logic [NUM_RULES-1:0]             en,
    input logic [NUM_RULES*FIELD_WIDTH-1:0] val,
    input logic [NUM_RULES*FIELD_WIDTH-1:0] msk
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (en[i] && (((field ^ val[i*FIELD_WIDTH +: FIELD_WIDTH]) &
                     msk[i*FIELD_WIDTH +: FIELD_WIDTH]) == '0)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  logic [1:0]              state;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   tdata_p1;
  logic [DATA_WIDTH/8-1:0] tkeep_p1;
  logic                    tlast_p1;

  logic match_p0;
  logic fwd_p0;
  logic out_free;
  logic accept;
  logic load_p0;

  // Stage 0: header decision and handshake. Config only matters while in HDR,
  // so mid-packet config changes cannot touch a packet already in flight.
  always_comb begin
    match_p0  = rule_match(in_tdata[FIELD_LSB +: FIELD_WIDTH], cfg_rule_en,
                           cfg_rule_value, cfg_rule_mask);
    fwd_p0    = cfg_mode ? !match_p0 : match_p0;
    out_free  = !vld_p1 || out_tready;
    // Beats being dropped never wait on the output register.
    in_tready = (state == ST_DROP) || (state == ST_HDR && !fwd_p0) || out_free;
    accept    = in_tvalid && in_tready;
    load_p0   = accept && ((state == ST_HDR && fwd_p0) || (state == ST_PASS));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_HDR;
      pass_count <= '0;
      drop_count <= '0;
    end else if (accept) begin
      case (state)
        ST_HDR: begin
          if (fwd_p0) pass_count <= pass_count + COUNT_WIDTH'(1);
          else        drop_count <= drop_count + COUNT_WIDTH'(1);
          if (!in_tlast) state <= fwd_p0 ? ST_PASS : ST_DROP;
        end
        ST_PASS, ST_DROP: begin
          if (in_tlast) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // Stage 1: output register, held while stalled downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= in_tdata;
      tkeep_p1 <= in_tkeep;
      tlast_p1 <= in_tlast;
    end else if (out_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_tvalid = vld_p1;
  assign out_tdata  = tdata_p1;
  assign out_tkeep  = tkeep_p1;
  assign out_tlast  = tlast_p1;

endmodule
